// File: rtl/phy_rx_lane_deskew.sv
// N-lane RX un-striper: each lane locks on COM, buffers in its own FIFO, and all lanes pop in lockstep.
// Registered output one edge after the last lane's byte lands; no backpressure, overflow or misalignment flushes and relocks.
module phy_rx_lane_deskew #(
    parameter int         LANES = 4,
    parameter int         DEPTH = 8,
    parameter logic [7:0] COM   = 8'hBC
) (
    input  logic               clk_f,
    input  logic               reset_L,
    input  logic [8*LANES-1:0] lane_data,
    input  logic [LANES-1:0]   lane_valid,
    output logic [8*LANES-1:0] data_out,
    output logic               valid_out,
    output logic               aligned,
    output logic               skew_err,
    output logic               fifo_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {SEARCH = 1'b0, RUN = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [LANES-1:0]         lock_q, lock_d;
    logic [LANES-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LANES-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            skew_cnt_q, skew_cnt_d;
    logic [8*LANES-1:0]       data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     skew_err_q, skew_err_d;
    logic                     fifo_ovf_q, fifo_ovf_d;
    logic [7:0]               mem_q [LANES][DEPTH];

    logic [LANES-1:0]         empty, full, wr_en, head_com;
    logic [8*LANES-1:0]       head_word;
    logic                     pop, flush;

    always_comb begin
        empty     = '0;
        full      = '0;
        wr_en     = '0;
        head_com  = '0;
        head_word = '0;
        for (int i = 0; i < LANES; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                       (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
            wr_en[i] = lane_valid[i] && lock_q[i];
            head_word[8*i +: 8] = mem_q[i][rd_ptr_q[i][AW-1:0]];
            head_com[i] = (mem_q[i][rd_ptr_q[i][AW-1:0]] == COM);
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        skew_cnt_d = skew_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        skew_err_d = 1'b0;
        fifo_ovf_d = 1'b0;
        pop        = 1'b0;

        // Space freed by a same-cycle pop is not usable by this write.
        if ((wr_en & full) != '0)
            fifo_ovf_d = 1'b1;

        if (state_q == SEARCH) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_valid[i] && !lock_q[i] && lane_data[8*i +: 8] == COM)
                    lock_d[i] = 1'b1;
            end
            if (&lock_q) begin
                state_d = RUN;
            end else if (|lock_q && !(&lock_d)) begin
                // skew_cnt_q holds edges since first lock, minus one
                if (skew_cnt_q == PW'(DEPTH - 2))
                    skew_err_d = 1'b1;
                else
                    skew_cnt_d = skew_cnt_q + PW'(1);
            end
        end else if (empty == '0) begin
            pop = 1'b1;
            if (&head_com) begin
                valid_d = 1'b0;
            end else if (|head_com) begin
                skew_err_d = 1'b1;
            end else begin
                data_d  = head_word;
                valid_d = 1'b1;
            end
        end

        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i])
                wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
            if (pop)
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        end

        flush = skew_err_d || fifo_ovf_d;
        if (flush) begin
            state_d    = SEARCH;
            lock_d     = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            skew_cnt_d = '0;
            data_d     = data_q;
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            state_q    <= SEARCH;
            lock_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            skew_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            skew_err_q <= 1'b0;
            fifo_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            skew_cnt_q <= skew_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            skew_err_q <= skew_err_d;
            fifo_ovf_q <= fifo_ovf_d;
        end
    end

    always_ff @(posedge clk_f) begin
        for (int i = 0; i < LANES; i++) begin
            if (reset_L && wr_en[i] && !flush)
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= lane_data[8*i +: 8];
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign aligned   = (state_q == RUN);
    assign skew_err  = skew_err_q;
    assign fifo_ovf  = fifo_ovf_q;

endmodule

// File: tb/tb_phy_rx_lane_deskew.sv
// Randomised and directed bench for phy_rx_lane_deskew against a queue-based lane model.
module tb_phy_rx_lane_deskew;
    localparam int          LANES = 4;
    localparam int          DEPTH = 8;
    localparam logic [7:0]  COM   = 8'hBC;
    localparam logic [31:0] COM4  = {4{8'hBC}};

    logic        clk_f = 1'b0;
    logic        reset_L;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid;
    logic [31:0] data_out;
    logic        valid_out, aligned, skew_err, fifo_ovf;

    always #5 clk_f = ~clk_f;

    phy_rx_lane_deskew #(.LANES(LANES), .DEPTH(DEPTH), .COM(COM)) dut (
        .clk_f     (clk_f),
        .reset_L   (reset_L),
        .lane_data (lane_data),
        .lane_valid(lane_valid),
        .data_out  (data_out),
        .valid_out (valid_out),
        .aligned   (aligned),
        .skew_err  (skew_err),
        .fifo_ovf  (fifo_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Model: one byte queue per lane, lock bits, and a timestamp of the first lock.
    logic [7:0]  mq [LANES][$];
    logic [3:0]  m_lock = '0;
    bit          m_run = 0;
    int          m_cyc = 0;
    int          m_first_lock = 0;
    logic [31:0] m_data = '0;
    bit          m_valid = 0, m_skew = 0, m_ovf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [31:0] d, input logic [3:0] v, input logic rst_n);
        logic [3:0]  pre_lock, new_lock;
        logic [31:0] w;
        bit          ovf, se, vld, all_full;
        int          ncom;
        m_cyc++;
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) mq[i].delete();
            m_lock = '0; m_run = 0; m_data = '0; m_valid = 0; m_skew = 0; m_ovf = 0;
            return;
        end
        ovf = 0; se = 0; vld = 0;
        pre_lock = m_lock;
        new_lock = m_lock;
        for (int i = 0; i < LANES; i++)
            if (v[i] && pre_lock[i] && mq[i].size() == DEPTH) ovf = 1;
        if (!m_run) begin
            for (int i = 0; i < LANES; i++)
                if (v[i] && !pre_lock[i] && d[8*i +: 8] == COM) new_lock[i] = 1'b1;
            if (pre_lock == 4'hF)
                m_run = 1;
            else if (pre_lock != 0 && new_lock != 4'hF && (m_cyc - m_first_lock) >= DEPTH - 1)
                se = 1;
            if (pre_lock == 0 && new_lock != 0) m_first_lock = m_cyc;
        end else begin
            all_full = 1;
            for (int i = 0; i < LANES; i++) if (mq[i].size() == 0) all_full = 0;
            if (all_full) begin
                ncom = 0;
                for (int i = 0; i < LANES; i++) begin
                    w[8*i +: 8] = mq[i].pop_front();
                    if (w[8*i +: 8] == COM) ncom++;
                end
                if (ncom == 0) begin
                    m_data = w;
                    vld = 1;
                end else if (ncom != LANES) begin
                    se = 1;
                end
            end
        end
        for (int i = 0; i < LANES; i++)
            if (v[i] && pre_lock[i]) mq[i].push_back(d[8*i +: 8]);
        m_lock = new_lock;
        if (ovf || se) begin
            for (int i = 0; i < LANES; i++) mq[i].delete();
            m_lock = '0; m_run = 0; vld = 0;
        end
        m_valid = vld; m_skew = se; m_ovf = ovf;
    endtask

    task automatic cyc(input logic [31:0] d, input logic [3:0] v, input logic rst_n);
        lane_data  = d;
        lane_valid = v;
        reset_L    = rst_n;
        @(posedge clk_f);
        model_step(d, v, rst_n);
        #1;
    endtask

    always @(negedge clk_f) begin
        if (chk_en) begin
            check("data_out",  data_out,  m_data);
            check("valid_out", valid_out, {31'b0, m_valid});
            check("aligned",   aligned,   {31'b0, m_run});
            check("skew_err",  skew_err,  {31'b0, m_skew});
            check("fifo_ovf",  fifo_ovf,  {31'b0, m_ovf});
        end
    end

    logic [31:0] hd [16];
    logic [3:0]  hv [16];
    int          dly [LANES];
    logic [31:0] w, ld, first_w, last_w;
    logic [3:0]  v, lv;
    int          r, b, li, idx, nv;

    initial begin
        reset_L = 1'b0; lane_data = '0; lane_valid = '0;
        cyc('0, '0, 1'b0);
        chk_en = 1;
        cyc('0, '0, 1'b0);
        check("reset_data", data_out, 32'h0);
        check("reset_aligned", aligned, 1'b0);

        // All lanes COM, then one word: visible two edges after COM.
        cyc(COM4, 4'hF, 1'b1);
        check("t1_not_aligned_at_com", aligned, 1'b0);
        cyc(32'h44332211, 4'hF, 1'b1);
        check("t1_aligned", aligned, 1'b1);
        check("t1_no_valid_yet", valid_out, 1'b0);
        cyc('0, '0, 1'b1);
        check("t1_data", data_out, 32'h44332211);
        check("t1_valid", valid_out, 1'b1);
        check("t1_model_data", m_data, 32'h44332211);

        // All-COM word in RUN is dropped; a lone COM misaligns.
        cyc(COM4, 4'hF, 1'b1);
        cyc('0, '0, 1'b1);
        check("t4_com_dropped", valid_out, 1'b0);
        check("t4_still_aligned", aligned, 1'b1);
        cyc(32'h4433BC11, 4'hF, 1'b1);
        cyc('0, '0, 1'b1);
        check("t4_skew_err", skew_err, 1'b1);
        check("t4_unaligned", aligned, 1'b0);
        check("t4_data_held", data_out, 32'h44332211);

        // Lane 2 arrives three cycles late; other lanes carry garbage-free data.
        nv = 0; first_w = '0; last_w = '0;
        for (int c = 0; c < 13; c++) begin
            for (int i = 0; i < LANES; i++) begin
                int t;
                t = c - ((i == 2) ? 3 : 0);
                if (t < 0) begin
                    ld[8*i +: 8] = 8'h00; lv[i] = 1'b1;
                end else if (t == 0) begin
                    ld[8*i +: 8] = COM; lv[i] = 1'b1;
                end else if (t <= 6) begin
                    ld[8*i +: 8] = 8'(8'h10 * t + i); lv[i] = 1'b1;
                end else begin
                    ld[8*i +: 8] = 8'h00; lv[i] = 1'b0;
                end
            end
            cyc(ld, lv, 1'b1);
            if (valid_out) begin
                if (nv == 0) first_w = data_out;
                last_w = data_out;
                nv++;
            end
        end
        check("t2_count", nv, 6);
        check("t2_first", first_w, 32'h13121110);
        check("t2_last", last_w, 32'h63626160);
        check("t2_aligned", aligned, 1'b1);

        // Lane 0 silent: lanes 1..3 overflow on their ninth write.
        for (int j = 1; j <= 9; j++) begin
            cyc({4{8'(8'h20 + j)}}, 4'hE, 1'b1);
            if (j == 8) check("t5_no_ovf_yet", fifo_ovf, 1'b0);
        end
        check("t5_ovf", fifo_ovf, 1'b1);
        check("t5_unaligned", aligned, 1'b0);

        // Lane 3 never locks: skew error seven edges after the first lock.
        cyc({8'h55, COM, COM, COM}, 4'hF, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            cyc({8'h55, {3{8'(8'h30 + j)}}}, 4'hF, 1'b1);
            if (j == 6) check("t3_no_err_yet", skew_err, 1'b0);
        end
        check("t3_skew_err", skew_err, 1'b1);
        check("t3_unaligned", aligned, 1'b0);

        // Reset mid-stream, then relock.
        cyc(COM4, 4'hF, 1'b1);
        cyc(32'h04030201, 4'hF, 1'b1);
        cyc(32'h08070605, 4'hF, 1'b1);
        check("t6_pre_reset_data", data_out, 32'h04030201);
        cyc(32'h0c0b0a09, 4'hF, 1'b0);
        check("t6_reset_data", data_out, 32'h0);
        check("t6_reset_valid", valid_out, 1'b0);
        check("t6_reset_aligned", aligned, 1'b0);
        cyc(32'h0c0b0a09, 4'hF, 1'b1);
        cyc(32'h0c0b0a09, 4'hF, 1'b1);
        check("t6_no_lock_without_com", aligned, 1'b0);
        cyc(COM4, 4'hF, 1'b1);
        cyc(32'h0d0c0b0a, 4'hF, 1'b1);
        cyc('0, '0, 1'b1);
        check("t6_relock_data", data_out, 32'h0d0c0b0a);
        check("t6_relock_valid", valid_out, 1'b1);

        // Random striped stream through per-lane delay lines.
        for (int k = 0; k < 16; k++) begin hd[k] = '0; hv[k] = '0; end
        for (int i = 0; i < LANES; i++) dly[i] = 0;
        nv = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0)
                for (int i = 0; i < LANES; i++) dly[i] = $urandom_range(0, 4);
            r = $urandom_range(0, 99);
            v = ($urandom_range(0, 9) != 0) ? 4'hF : 4'h0;
            if (r < 8) begin
                w = COM4;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    b = $urandom_range(0, 255);
                    if (b == int'(COM)) b = 0;
                    w[8*i +: 8] = 8'(b);
                end
            end
            if (r == 99) begin
                li = $urandom_range(0, 3);
                w[8*li +: 8] = COM;
            end
            if ($urandom_range(0, 199) == 0) begin
                li = $urandom_range(0, 3);
                v[li] = 1'b0;
            end
            hd[n % 16] = w;
            hv[n % 16] = v;
            for (int i = 0; i < LANES; i++) begin
                idx = (n + 16 - dly[i]) % 16;
                ld[8*i +: 8] = hd[idx][8*i +: 8];
                lv[i] = hv[idx][i];
            end
            cyc(ld, lv, ($urandom_range(0, 399) != 0));
            if (valid_out) nv++;
        end
        check("rand_activity", (nv > 100), 1'b1);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
